// File: rtl/horner_bf16_seq.sv
// Sequences a Horner evaluation of a BF16 polynomial through an external FMA unit; result after DEGREE*(FMA_LAT+1) cycles.
// One evaluation at a time, held in DONE until out_ready; define HORNER_NAN_FLAG_EN to add the sticky out_nan output.
module horner_bf16_seq #(
  parameter int DEGREE  = 6,
  parameter int FMA_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
  input  logic        coef_we,
  input  logic [3:0]  coef_addr,
  input  logic [15:0] coef_data,
  output logic [15:0] fma_mul0,
  output logic [15:0] fma_mul1,
  output logic [15:0] fma_add,
  input  logic [15:0] fma_out
`ifdef HORNER_NAN_FLAG_EN
  ,
  output logic        out_nan
`endif
);

  localparam int WW = (FMA_LAT > 0) ? $clog2(FMA_LAT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  logic [15:0]     r_coef [16];
  logic [15:0]     r_acc;
  logic [15:0]     r_x;
  logic [15:0]     r_p;
  logic [3:0]      r_step;
  logic [WW-1:0]   r_wait;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            w_run;
  logic            w_sample;

  assign w_run    = (r_state == S_RUN);
  assign w_sample = (r_wait == WW'(FMA_LAT));

  // Operands stay constant for a whole step; coef writes are blocked outside IDLE.
  assign fma_mul0  = w_run ? r_acc           : 16'h0000;
  assign fma_mul1  = w_run ? r_x             : 16'h0000;
  assign fma_add   = w_run ? r_coef[r_step]  : 16'h0000;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_p     = r_p;

`ifdef HORNER_NAN_FLAG_EN
  logic r_nan;
  logic w_fma_nan;
  assign w_fma_nan = (fma_out[14:7] == 8'hFF) && (fma_out[6:0] != 7'd0);
  assign out_nan   = r_nan;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) r_coef[k] <= 16'h0000;
    end else if (coef_we && (r_state == S_IDLE) && (coef_addr <= 4'(DEGREE))) begin
      r_coef[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_p         <= 16'h0000;
      r_acc       <= 16'h0000;
      r_x         <= 16'h0000;
      r_step      <= 4'd0;
      r_wait      <= '0;
`ifdef HORNER_NAN_FLAG_EN
      r_nan       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x        <= in_x;
            r_acc      <= r_coef[DEGREE];
            r_step     <= 4'(DEGREE - 1);
            r_wait     <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
`ifdef HORNER_NAN_FLAG_EN
            r_nan      <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          if (w_sample) begin
            r_acc <= fma_out;
`ifdef HORNER_NAN_FLAG_EN
            r_nan <= r_nan | w_fma_nan;
`endif
            if (r_step == 4'd0) begin
              r_p         <= fma_out;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_step <= r_step - 4'd1;
              r_wait <= '0;
            end
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_horner_bf16_seq.sv
// Bench for horner_bf16_seq: two DEGREE=2 instances (FMA_LAT 0 and 2) driven by a BF16 FMA model.
module tb_horner_bf16_seq;

  localparam int D = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid [2];
  logic        in_ready [2];
  logic [15:0] in_x [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] out_p [2];
  logic        coef_we [2];
  logic [3:0]  coef_addr [2];
  logic [15:0] coef_data [2];
  logic [15:0] fma_mul0 [2];
  logic [15:0] fma_mul1 [2];
  logic [15:0] fma_add [2];
  logic [15:0] fma_out0, fma_out1;
  logic        out_nan [2];

  int errors = 0;
  int checks = 0;
  int lat_of [2];
  logic [15:0] mc [2][3];

  // ---------------- BF16 helpers (denormals flushed) ----------------
  function automatic real bf2r(input logic [15:0] b);
    logic [63:0] d;
    if (b[14:7] == 8'h00)      d = {b[15], 63'd0};
    else if (b[14:7] == 8'hFF) d = {b[15], 11'h7FF, b[6:0], 45'd0};
    else                       d = {b[15], 11'(b[14:7]) + 11'd896, b[6:0], 45'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [15:0] r2bf(input real r);
    logic [63:0] d;
    int          e;
    logic [7:0]  m;
    d = $realtobits(r);
    if (d[62:52] == 11'h7FF) return (d[51:0] != 0) ? 16'h7FC0 : {d[63], 15'h7F80};
    if (d[62:52] == 11'h000) return {d[63], 15'd0};
    e = int'(d[62:52]) - 896;
    m = {1'b0, d[51:45]};
    if (d[44] && ((|d[43:0]) || m[0])) m = m + 8'd1;
    if (m[7]) begin e = e + 1; m = 8'd0; end
    if (e >= 255) return {d[63], 15'h7F80};
    if (e <= 0)   return {d[63], 15'd0};
    return {d[63], 8'(e), m[6:0]};
  endfunction

  function automatic logic is_nan(input logic [15:0] b);
    return (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
  endfunction

  function automatic logic [15:0] bf16_fma(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    if (is_nan(a) || is_nan(b) || is_nan(c)) return 16'h7FC0;
    return r2bf(bf2r(a) * bf2r(b) + bf2r(c));
  endfunction

  // Reference: plain Horner loop over the coefficient list.
  function automatic logic [15:0] ref_poly(input logic [15:0] c0, input logic [15:0] c1,
                                           input logic [15:0] c2, input logic [15:0] x);
    logic [15:0] cs [3];
    logic [15:0] acc;
    cs[0] = c0; cs[1] = c1; cs[2] = c2;
    acc = cs[D];
    for (int i = D - 1; i >= 0; i--) acc = bf16_fma(acc, x, cs[i]);
    return acc;
  endfunction

  function automatic logic [15:0] rnd_bf();
    logic [15:0] v;
    if ($urandom_range(7) == 0) return 16'h0000;
    v = {1'($urandom_range(1)), 8'($urandom_range(130, 124)), 7'($urandom_range(127))};
    return v;
  endfunction

  // ---------------- external FMA models ----------------
  logic [15:0] pipe1, pipe2;
  always_comb fma_out0 = bf16_fma(fma_mul0[0], fma_mul1[0], fma_add[0]);
  always_ff @(posedge clk) begin
    pipe1 <= bf16_fma(fma_mul0[1], fma_mul1[1], fma_add[1]);
    pipe2 <= pipe1;
  end
  assign fma_out1 = pipe2;

  horner_bf16_seq #(.DEGREE(D), .FMA_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_x(in_x[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_p(out_p[0]),
    .coef_we(coef_we[0]), .coef_addr(coef_addr[0]), .coef_data(coef_data[0]),
    .fma_mul0(fma_mul0[0]), .fma_mul1(fma_mul1[0]), .fma_add(fma_add[0]),
    .fma_out(fma_out0)
`ifdef HORNER_NAN_FLAG_EN
    , .out_nan(out_nan[0])
`endif
  );

  horner_bf16_seq #(.DEGREE(D), .FMA_LAT(2)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_x(in_x[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_p(out_p[1]),
    .coef_we(coef_we[1]), .coef_addr(coef_addr[1]), .coef_data(coef_data[1]),
    .fma_mul0(fma_mul0[1]), .fma_mul1(fma_mul1[1]), .fma_add(fma_add[1]),
    .fma_out(fma_out1)
`ifdef HORNER_NAN_FLAG_EN
    , .out_nan(out_nan[1])
`endif
  );

  // ---------------- bench tasks ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load(input int u, input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2);
    logic [15:0] cs [3];
    cs[0] = c0; cs[1] = c1; cs[2] = c2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      coef_we[u] = 1'b1; coef_addr[u] = 4'(i); coef_data[u] = cs[i];
      mc[u][i] = cs[i];
    end
    @(negedge clk);
    coef_we[u] = 1'b0;
  endtask

  task automatic start(input int u, input logic [15:0] x);
    @(negedge clk);
    chk("accept_ready", in_ready[u], 1'b1);
    in_valid[u] = 1'b1; in_x[u] = x;
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
  endtask

  task automatic wait_done(input int u, output int lat);
    lat = 0;
    while (!out_valid[u] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_hs(input int u);
    @(negedge clk);
    out_ready[u] = 1'b1;
    @(posedge clk); #1;
    out_ready[u] = 1'b0;
    chk("hs_in_ready", in_ready[u], 1'b1);
    chk("hs_out_valid", out_valid[u], 1'b0);
  endtask

  task automatic eval_chk(input string nm, input int u, input logic [15:0] x, input logic [15:0] exp_p);
    int lat;
    start(u, x);
    wait_done(u, lat);
    chk({nm, "_lat"}, lat, lat_of[u]);
    chk({nm, "_p"}, out_p[u], exp_p);
    finish_hs(u);
  endtask

  typedef struct {
    int          u;
    logic [15:0] c0, c1, c2, x, p;
  } vec_t;

  vec_t tv [4];

  initial begin
    int          lat;
    logic [15:0] rc0, rc1, rc2, rx;
    int          ru;

    lat_of[0] = D * (0 + 1);
    lat_of[1] = D * (2 + 1);
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0; in_x[u] = 16'h0; out_ready[u] = 1'b0;
      coef_we[u] = 1'b0; coef_addr[u] = 4'h0; coef_data[u] = 16'h0;
      for (int i = 0; i < 3; i++) mc[u][i] = 16'h0;
    end

    tv[0] = '{u: 0, c0: 16'h3F80, c1: 16'h3F80, c2: 16'h3F80, x: 16'h3F80, p: 16'h4040};
    tv[1] = '{u: 1, c0: 16'h3F80, c1: 16'h4000, c2: 16'h4040, x: 16'h4000, p: 16'h4188};
    tv[2] = '{u: 0, c0: 16'h0000, c1: 16'h0000, c2: 16'h4000, x: 16'h4040, p: 16'h4190};
    tv[3] = '{u: 1, c0: 16'h3F00, c1: 16'hBF80, c2: 16'h3F80, x: 16'h3F00, p: 16'h3E80};

    // Reset state
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_in_ready", in_ready[u], 1'b1);
      chk("rst_out_valid", out_valid[u], 1'b0);
      chk("rst_out_p", out_p[u], 16'h0);
      chk("rst_fma_mul0", fma_mul0[u], 16'h0);
      chk("rst_fma_mul1", fma_mul1[u], 16'h0);
      chk("rst_fma_add", fma_add[u], 16'h0);
    end
    rst = 1'b0;

    // Directed table
    for (int t = 0; t < 4; t++) begin
      load(tv[t].u, tv[t].c0, tv[t].c1, tv[t].c2);
      eval_chk("table", tv[t].u, tv[t].x, tv[t].p);
    end

    // Randomised against the reference polynomial
    for (int n = 0; n < 40; n++) begin
      ru = int'($urandom_range(1));
      rc0 = rnd_bf(); rc1 = rnd_bf(); rc2 = rnd_bf(); rx = rnd_bf();
      load(ru, rc0, rc1, rc2);
      eval_chk("rand", ru, rx, ref_poly(rc0, rc1, rc2, rx));
    end

    // DONE stall: output held, in_valid pulses ignored
    load(1, 16'h3F80, 16'h4000, 16'h4040);
    start(1, 16'h4000);
    wait_done(1, lat);
    chk("stall_lat", lat, lat_of[1]);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid[1] = k[0]; in_x[1] = 16'h3F80;
      @(posedge clk); #1;
      chk("stall_out_valid", out_valid[1], 1'b1);
      chk("stall_out_p", out_p[1], 16'h4188);
      chk("stall_in_ready", in_ready[1], 1'b0);
    end
    in_valid[1] = 1'b0;
    finish_hs(1);
    repeat (8) @(posedge clk);
    #1;
    chk("stall_no_queue", out_valid[1], 1'b0);

    // Coefficient writes during RUN and DONE are dropped
    start(1, 16'h4000);
    @(negedge clk);
    coef_we[1] = 1'b1; coef_addr[1] = 4'd0; coef_data[1] = 16'h4000;
    @(negedge clk);
    coef_we[1] = 1'b0;
    wait_done(1, lat);
    chk("runwr_p", out_p[1], 16'h4188);
    @(negedge clk);
    coef_we[1] = 1'b1; coef_addr[1] = 4'd0; coef_data[1] = 16'h4000;
    @(negedge clk);
    coef_we[1] = 1'b0;
    finish_hs(1);
    eval_chk("runwr_next", 1, 16'h4000, 16'h4188);

    // Write and accept in the same cycle: old c2 seeds acc, new c2 used next time
    load(0, 16'h3F80, 16'h3F80, 16'h3F80);
    @(negedge clk);
    in_valid[0] = 1'b1; in_x[0] = 16'h3F80;
    coef_we[0] = 1'b1; coef_addr[0] = 4'd2; coef_data[0] = 16'h4000;
    @(posedge clk); #1;
    in_valid[0] = 1'b0; coef_we[0] = 1'b0;
    wait_done(0, lat);
    chk("samecyc_lat", lat, lat_of[0]);
    chk("samecyc_p", out_p[0], 16'h4040);
    finish_hs(0);
    eval_chk("samecyc_next", 0, 16'h3F80, 16'h4080);

    // Out-of-range address ignored
    @(negedge clk);
    coef_we[0] = 1'b1; coef_addr[0] = 4'd3; coef_data[0] = 16'h7F80;
    @(negedge clk);
    coef_addr[0] = 4'd15;
    @(negedge clk);
    coef_we[0] = 1'b0;
    eval_chk("badaddr", 0, 16'h3F80, 16'h4080);

`ifdef HORNER_NAN_FLAG_EN
    load(0, 16'h3F80, 16'h3F80, 16'h7FC0);
    start(0, 16'h3F80);
    wait_done(0, lat);
    chk("nan_p", out_p[0], ref_poly(16'h3F80, 16'h3F80, 16'h7FC0, 16'h3F80));
    chk("nan_flag_set", out_nan[0], 1'b1);
    finish_hs(0);
    load(0, 16'h3F80, 16'h3F80, 16'h3F80);
    start(0, 16'h3F80);
    wait_done(0, lat);
    chk("nan_flag_clr", out_nan[0], 1'b0);
    finish_hs(0);
`endif

    // Asynchronous reset in the middle of RUN
    load(1, 16'h3F80, 16'h4000, 16'h4040);
    start(1, 16'h4000);
    @(posedge clk); #1;
    chk("pre_rst_mul1", fma_mul1[1], 16'h4000);
    #2 rst = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("arst_out_valid", out_valid[u], 1'b0);
      chk("arst_in_ready", in_ready[u], 1'b1);
      chk("arst_fma_mul0", fma_mul0[u], 16'h0);
      chk("arst_fma_mul1", fma_mul1[u], 16'h0);
      chk("arst_fma_add", fma_add[u], 16'h0);
      chk("arst_out_p", out_p[u], 16'h0);
      for (int i = 0; i < 3; i++) mc[u][i] = 16'h0;
    end
    @(negedge clk);
    rst = 1'b0;
    eval_chk("post_rst1", 1, 16'h4000, ref_poly(mc[1][0], mc[1][1], mc[1][2], 16'h4000));
    eval_chk("post_rst0", 0, 16'h3F80, ref_poly(mc[0][0], mc[0][1], mc[0][2], 16'h3F80));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
